// File: rtl/motion_detector_p.sv
// Frame-differencing motion detector: compares each pixel against a stored
// reference frame, flags motion per pixel and reports per-frame count and bounding box.
module motion_detector_p #(
  parameter int unsigned H_RES     = 320,
  parameter int unsigned V_RES     = 240,
  parameter int unsigned X_WIDTH   = 9,
  parameter int unsigned Y_WIDTH   = 8,
  parameter int unsigned CH_WIDTH  = 5,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned CNT_WIDTH = 17
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       pix_valid,
  input  logic [X_WIDTH-1:0]         pix_x,
  input  logic [Y_WIDTH-1:0]         pix_y,
  input  logic [NUM_CH*CH_WIDTH-1:0] pix_data,
  input  logic                       frame_start,
  input  logic [CH_WIDTH-1:0]        threshold,
  input  logic [1:0]                 mode,
  input  logic                       freeze,
  output logic                       out_valid,
  output logic [X_WIDTH-1:0]         out_x,
  output logic [Y_WIDTH-1:0]         out_y,
  output logic [NUM_CH-1:0]          out_pixel,
  output logic                       frame_done,
  output logic [CNT_WIDTH-1:0]       motion_count,
  output logic                       bbox_valid,
  output logic [X_WIDTH-1:0]         bbox_x0,
  output logic [X_WIDTH-1:0]         bbox_x1,
  output logic [Y_WIDTH-1:0]         bbox_y0,
  output logic [Y_WIDTH-1:0]         bbox_y1
);
  localparam int unsigned PW    = NUM_CH * CH_WIDTH;
  localparam int unsigned DEPTH = H_RES * V_RES;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {WARMUP = 2'd0, FILL = 2'd1, ARMED = 2'd2} state_t;
  state_t state_q, state_d;

  logic [PW-1:0] ref_mem [DEPTH];

  logic          accept_c;
  logic [AW-1:0] pix_addr_c;
  assign accept_c   = pix_valid && (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
  assign pix_addr_c = AW'(pix_y) * AW'(H_RES) + AW'(pix_x);

  // Stage 1 pipeline registers
  logic                s1_valid, s1_freeze;
  logic [X_WIDTH-1:0]  s1_x;
  logic [Y_WIDTH-1:0]  s1_y;
  logic [AW-1:0]       s1_addr;
  logic [PW-1:0]       s1_data, rd_q;
  logic [CH_WIDTH-1:0] s1_thr;
  logic [1:0]          s1_mode;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_freeze <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_addr   <= '0;
      s1_data   <= '0;
      s1_thr    <= '0;
      s1_mode   <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_freeze <= freeze;
        s1_x      <= pix_x;
        s1_y      <= pix_y;
        s1_addr   <= pix_addr_c;
        s1_data   <= pix_data;
        s1_thr    <= threshold;
        s1_mode   <= mode;
      end
    end
  end

  // Reference RAM: synchronous read at acceptance, write one cycle later
  always_ff @(posedge clock) begin
    if (accept_c) rd_q <= ref_mem[pix_addr_c];
    if (s1_valid && !s1_freeze) ref_mem[s1_addr] <= s1_data;
  end

  // Last write, used to bypass the RAM read it raced with
  logic          wr_valid_q;
  logic [AW-1:0] wr_addr_q;
  logic [PW-1:0] wr_data_q, old_c;
  assign old_c = (wr_valid_q && (wr_addr_q == s1_addr)) ? wr_data_q : rd_q;

  logic                motion_c;
  logic [NUM_CH-1:0]   live_msb_c, ref_msb_c, pixel_c;
  logic [CH_WIDTH-1:0] new_ch_c, old_ch_c;
  logic [CH_WIDTH:0]   diff_c;

  always_comb begin
    motion_c   = 1'b0;
    live_msb_c = '0;
    ref_msb_c  = '0;
    new_ch_c   = '0;
    old_ch_c   = '0;
    diff_c     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      new_ch_c = s1_data[c*CH_WIDTH +: CH_WIDTH];
      old_ch_c = old_c[c*CH_WIDTH +: CH_WIDTH];
      diff_c   = (new_ch_c >= old_ch_c) ? ({1'b0, new_ch_c} - {1'b0, old_ch_c})
                                        : ({1'b0, old_ch_c} - {1'b0, new_ch_c});
      if (diff_c > {1'b0, s1_thr}) motion_c = 1'b1;
      live_msb_c[c] = new_ch_c[CH_WIDTH-1];
      ref_msb_c[c]  = old_ch_c[CH_WIDTH-1];
    end
    if (state_q != ARMED) motion_c = 1'b0;
    pixel_c = live_msb_c;
    case (s1_mode)
      2'd1:    pixel_c = ref_msb_c;
      2'd2:    pixel_c = {NUM_CH{motion_c}};
      2'd3:    pixel_c = motion_c ? '1 : live_msb_c;
      default: pixel_c = live_msb_c;
    endcase
  end

  logic mot_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_pixel  <= '0;
      mot_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      out_valid  <= s1_valid;
      mot_q      <= s1_valid && motion_c;
      wr_valid_q <= s1_valid && !s1_freeze;
      wr_addr_q  <= s1_addr;
      wr_data_q  <= s1_data;
      if (s1_valid) begin
        out_x     <= s1_x;
        out_y     <= s1_y;
        out_pixel <= pixel_c;
      end
    end
  end

  // Frame statistics: a frame boundary clears first, so a coincident pixel opens the new frame
  logic                 latch_c;
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d, base_cnt_c;
  logic [X_WIDTH-1:0]   acc_x0_q, acc_x1_q, acc_x0_d, acc_x1_d, base_x0_c, base_x1_c;
  logic [Y_WIDTH-1:0]   acc_y0_q, acc_y1_q, acc_y0_d, acc_y1_d, base_y0_c, base_y1_c;

  always_comb begin
    latch_c    = frame_start && (state_q == ARMED);
    base_cnt_c = latch_c ? '0 : acc_cnt_q;
    base_x0_c  = latch_c ? '0 : acc_x0_q;
    base_x1_c  = latch_c ? '0 : acc_x1_q;
    base_y0_c  = latch_c ? '0 : acc_y0_q;
    base_y1_c  = latch_c ? '0 : acc_y1_q;
    acc_cnt_d  = base_cnt_c;
    acc_x0_d   = base_x0_c;
    acc_x1_d   = base_x1_c;
    acc_y0_d   = base_y0_c;
    acc_y1_d   = base_y1_c;
    if (out_valid && mot_q) begin
      if (base_cnt_c != '1) acc_cnt_d = base_cnt_c + CNT_WIDTH'(1);
      if (base_cnt_c == '0) begin
        acc_x0_d = out_x;
        acc_x1_d = out_x;
        acc_y0_d = out_y;
        acc_y1_d = out_y;
      end else begin
        if (out_x < base_x0_c) acc_x0_d = out_x;
        if (out_x > base_x1_c) acc_x1_d = out_x;
        if (out_y < base_y0_c) acc_y0_d = out_y;
        if (out_y > base_y1_c) acc_y1_d = out_y;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_cnt_q    <= '0;
      acc_x0_q     <= '0;
      acc_x1_q     <= '0;
      acc_y0_q     <= '0;
      acc_y1_q     <= '0;
      frame_done   <= 1'b0;
      motion_count <= '0;
      bbox_valid   <= 1'b0;
      bbox_x0      <= '0;
      bbox_x1      <= '0;
      bbox_y0      <= '0;
      bbox_y1      <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      acc_x0_q   <= acc_x0_d;
      acc_x1_q   <= acc_x1_d;
      acc_y0_q   <= acc_y0_d;
      acc_y1_q   <= acc_y1_d;
      frame_done <= latch_c;
      if (latch_c) begin
        motion_count <= acc_cnt_q;
        bbox_valid   <= (acc_cnt_q != '0);
        bbox_x0      <= (acc_cnt_q != '0) ? acc_x0_q : '0;
        bbox_x1      <= (acc_cnt_q != '0) ? acc_x1_q : '0;
        bbox_y0      <= (acc_cnt_q != '0) ? acc_y0_q : '0;
        bbox_y1      <= (acc_cnt_q != '0) ? acc_y1_q : '0;
      end
    end
  end

  // Arming FSM
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= WARMUP;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WARMUP:  if (frame_start) state_d = FILL;
      FILL:    if (frame_start) state_d = ARMED;
      ARMED:   state_d = ARMED;
      default: state_d = WARMUP;
    endcase
  end

endmodule

// File: tb/tb_motion_detector_p.sv
// Scoreboard bench for motion_detector_p: directed pixels/frames push expectations,
// a negedge monitor pops and compares pixel outputs and frame statistics.
module tb_motion_detector_p;
  localparam int unsigned XW = 9, YW = 8, CW = 5, NC = 3, CNTW = 17;

  logic              clock = 1'b0;
  logic              resetn = 1'b1;
  logic              pix_valid = 1'b0;
  logic [XW-1:0]     pix_x = '0;
  logic [YW-1:0]     pix_y = '0;
  logic [NC*CW-1:0]  pix_data = '0;
  logic              frame_start = 1'b0;
  logic [CW-1:0]     threshold = '0;
  logic [1:0]        mode = '0;
  logic              freeze = 1'b0;
  logic              out_valid, frame_done, bbox_valid;
  logic [XW-1:0]     out_x, bbox_x0, bbox_x1;
  logic [YW-1:0]     out_y, bbox_y0, bbox_y1;
  logic [NC-1:0]     out_pixel;
  logic [CNTW-1:0]   motion_count;

  motion_detector_p dut (
    .clock(clock), .resetn(resetn), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .frame_start(frame_start), .threshold(threshold), .mode(mode),
    .freeze(freeze), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .out_pixel(out_pixel), .frame_done(frame_done), .motion_count(motion_count),
    .bbox_valid(bbox_valid), .bbox_x0(bbox_x0), .bbox_x1(bbox_x1),
    .bbox_y0(bbox_y0), .bbox_y1(bbox_y1)
  );

  typedef struct { int x; int y; logic [2:0] pix; int cyc; } pix_exp_t;
  typedef struct { int cnt; logic bv; int x0; int x1; int y0; int y1; } st_exp_t;

  pix_exp_t pq[$];
  st_exp_t  sq[$];
  pix_exp_t pe;
  st_exp_t  se;
  int checks = 0, errors = 0, cyc = 0, fd_count = 0, fd_snap = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a pixel or a frame report
  always @(negedge clock) begin
    if (resetn && out_valid) begin
      if (pq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid: got x=%0d y=%0d pixel=%b, required none", out_x, out_y, out_pixel);
      end else begin
        pe = pq.pop_front();
        chk("out_x", out_x, pe.x);
        chk("out_y", out_y, pe.y);
        chk("out_pixel", out_pixel, pe.pix);
        chk("latency_cycle", cyc, pe.cyc);
      end
    end
    if (resetn && frame_done) begin
      fd_count++;
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done: got count=%0d, required no frame_done", motion_count);
      end else begin
        se = sq.pop_front();
        chk("motion_count", motion_count, se.cnt);
        chk("bbox_valid", bbox_valid, se.bv);
        chk("bbox_x0", bbox_x0, se.x0);
        chk("bbox_x1", bbox_x1, se.x1);
        chk("bbox_y0", bbox_y0, se.y0);
        chk("bbox_y1", bbox_y1, se.y1);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int x, input int y, input logic [14:0] d, input logic [4:0] th,
                      input logic [1:0] md, input logic fz, input logic exp_out, input logic [2:0] ep);
    pix_valid = 1'b1;
    pix_x     = XW'(x);
    pix_y     = YW'(y);
    pix_data  = d;
    threshold = th;
    mode      = md;
    freeze    = fz;
    if (exp_out) pq.push_back('{x, y, ep, cyc + 2});
    tick();
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
  endtask

  task automatic exp_stats(input int c, input logic bv, input int x0, input int x1, input int y0, input int y1);
    sq.push_back('{c, bv, x0, x1, y0, y1});
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_x"}, out_x, 0);
    chk({tag, "_out_y"}, out_y, 0);
    chk({tag, "_out_pixel"}, out_pixel, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_motion_count"}, motion_count, 0);
    chk({tag, "_bbox_valid"}, bbox_valid, 0);
    chk({tag, "_bbox_x0"}, bbox_x0, 0);
    chk({tag, "_bbox_x1"}, bbox_x1, 0);
    chk({tag, "_bbox_y0"}, bbox_y0, 0);
    chk({tag, "_bbox_y1"}, bbox_y1, 0);
  endtask

  // Arming region: x 10..19, y 20..21; frame 3 raises channel 1 by 8 at x 12..16
  task automatic arm_frame(input int f);
    logic ch;
    for (int y = 20; y <= 21; y++)
      for (int x = 10; x <= 19; x++) begin
        ch = (f == 3) && (x >= 12) && (x <= 16);
        send(x, y, ch ? {5'd10, 5'd18, 5'd10} : {5'd10, 5'd10, 5'd10}, 5'd4, 2'd3, 1'b0,
             1'b1, ch ? 3'b111 : 3'b000);
      end
    idle(3);
  endtask

  task automatic frz_frame(input logic [14:0] d, input logic [4:0] th, input logic fz, input logic [2:0] ep);
    for (int x = 50; x <= 53; x++) send(x, 60, d, th, 2'd0, fz, 1'b1, ep);
    idle(3);
  endtask

  initial begin
    #2 resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero_outputs("reset");
    tick();
    resetn = 1'b1;
    tick();

    // Latency, mode 0 live MSBs
    send(5, 7, {5'd16, 5'd3, 5'd31}, 5'd4, 2'd0, 1'b0, 1'b1, 3'b101);
    idle(3);

    // Out-of-range pixels: no output and no write (x=320,y=0 aliases address of (0,1))
    send(0, 1, 15'd0, 5'd4, 2'd0, 1'b0, 1'b1, 3'b000);
    idle(2);
    send(320, 0, 15'h7fff, 5'd4, 2'd0, 1'b0, 1'b0, 3'b000);
    send(0, 240, 15'h7fff, 5'd4, 2'd0, 1'b0, 1'b0, 3'b000);
    idle(2);
    send(0, 1, 15'd0, 5'd4, 2'd1, 1'b0, 1'b1, 3'b000);
    idle(3);

    // Back-to-back same address: second sees first's data as reference
    send(3, 3, 15'd0, 5'd4, 2'd0, 1'b0, 1'b1, 3'b000);
    idle(2);
    send(3, 3, 15'h7fff, 5'd4, 2'd0, 1'b0, 1'b1, 3'b111);
    send(3, 3, 15'd0, 5'd4, 2'd1, 1'b0, 1'b1, 3'b111);
    idle(3);

    // Arming: fs1 -> FILL, fs2 -> ARMED, fs3 reports frame 2, fs4 reports frame 3
    fs();
    arm_frame(1);
    fs();
    arm_frame(2);
    chk("no_frame_done_before_armed", fd_count, 0);
    exp_stats(0, 1'b0, 0, 0, 0, 0);
    fs();
    arm_frame(3);
    exp_stats(10, 1'b1, 12, 16, 20, 21);
    fs();
    idle(3);

    // Threshold edge, mode 2: diff 4 at thr 4 is quiet, diff 5 is motion
    send(30, 30, 15'd0, 5'd31, 2'd2, 1'b0, 1'b1, 3'b000);
    idle(2);
    send(30, 30, {10'd0, 5'd4}, 5'd4, 2'd2, 1'b0, 1'b1, 3'b000);
    idle(2);
    send(30, 30, {10'd0, 5'd9}, 5'd4, 2'd2, 1'b0, 1'b1, 3'b111);
    idle(2);

    // frame_start in the cycle a motion pixel is presented: counted in the next frame
    send(40, 41, 15'd0, 5'd31, 2'd0, 1'b0, 1'b1, 3'b000);
    idle(2);
    send(40, 41, {10'd0, 5'd31}, 5'd0, 2'd2, 1'b0, 1'b1, 3'b111);
    idle(1);
    exp_stats(1, 1'b1, 30, 30, 30, 30);
    fs();
    idle(3);
    exp_stats(1, 1'b1, 40, 40, 41, 41);
    fs();
    idle(2);

    // Freeze: A as reference, then B,B frozen, then B,B unfrozen
    frz_frame(15'd0, 5'd31, 1'b0, 3'b000);
    exp_stats(0, 1'b0, 0, 0, 0, 0);
    fs();
    frz_frame({10'd0, 5'd20}, 5'd4, 1'b1, 3'b001);
    exp_stats(4, 1'b1, 50, 53, 60, 60);
    fs();
    frz_frame({10'd0, 5'd20}, 5'd4, 1'b1, 3'b001);
    exp_stats(4, 1'b1, 50, 53, 60, 60);
    fs();
    frz_frame({10'd0, 5'd20}, 5'd4, 1'b0, 3'b001);
    exp_stats(4, 1'b1, 50, 53, 60, 60);
    fs();
    frz_frame({10'd0, 5'd20}, 5'd4, 1'b0, 3'b001);
    exp_stats(0, 1'b0, 0, 0, 0, 0);
    fs();
    idle(3);
    chk("frame_done_total", fd_count, 9);

    // Reset mid-frame with a motion pixel in flight
    send(50, 60, 15'd0, 5'd4, 2'd2, 1'b1, 1'b0, 3'b000);
    resetn = 1'b0;
    tick();
    tick();
    @(negedge clock);
    check_zero_outputs("midreset");
    tick();
    resetn = 1'b1;
    tick();
    fd_snap = fd_count;
    send(50, 60, 15'd0, 5'd0, 2'd2, 1'b0, 1'b1, 3'b000);
    idle(2);
    fs();
    send(50, 60, {10'd0, 5'd31}, 5'd0, 2'd2, 1'b0, 1'b1, 3'b000);
    idle(2);
    fs();
    idle(3);
    chk("no_frame_done_after_reset", fd_count - fd_snap, 0);
    send(50, 60, 15'd0, 5'd0, 2'd2, 1'b0, 1'b1, 3'b111);
    idle(2);
    exp_stats(1, 1'b1, 50, 50, 60, 60);
    fs();
    idle(4);
    chk("frame_done_once_armed", fd_count - fd_snap, 1);

    chk("pixel_queue_drained", pq.size(), 0);
    chk("stats_queue_drained", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motion_detector_p.md
MOTION_DETECTOR_P -- requirements
Module: motion_detector_p

Interface
REQ-001 SHALL have parameters: H_RES, default 320, active pixels per line.
REQ-002 SHALL have parameters: V_RES, default 240, active lines per frame.
REQ-003 SHALL have parameters: X_WIDTH, default 9, width of pixel x coordinate.
REQ-004 SHALL have parameters: Y_WIDTH, default 8, width of pixel y coordinate.
REQ-005 SHALL have parameters: CH_WIDTH, default 5, bits per colour channel.
REQ-006 SHALL have parameters: NUM_CH, default 3, colour channels per pixel.
REQ-007 SHALL have parameters: CNT_WIDTH, default 17, width of the motion pixel counter.
REQ-008 SHALL have ports: clock  in  1  sole clock, all logic rising-edge.
REQ-009 SHALL have ports: resetn  in  1  asynchronous active-low reset.
REQ-010 SHALL have ports: pix_valid  in  1  qualifies pix_x/pix_y/pix_data this cycle.
REQ-011 SHALL have ports: pix_x  in  X_WIDTH; pix_y  in  Y_WIDTH  pixel coordinates.
REQ-012 SHALL have ports: pix_data  in  NUM_CH*CH_WIDTH  channel 0 in LSBs.
REQ-013 SHALL have ports: frame_start  in  1  one-cycle pulse at start of each input frame.
REQ-014 SHALL have ports: threshold  in  CH_WIDTH  per-channel absolute-difference threshold.
REQ-015 SHALL have ports: mode  in  2  output select.
REQ-016 SHALL have ports: freeze  in  1  holds the reference frame (background-subtraction mode).
REQ-017 SHALL have ports: out_valid  out  1; out_x  out  X_WIDTH; out_y  out  Y_WIDTH; out_pixel  out  NUM_CH.
REQ-018 SHALL have ports: frame_done  out  1; motion_count  out  CNT_WIDTH; bbox_valid  out  1; bbox_x0, bbox_x1  out  X_WIDTH; bbox_y0, bbox_y1  out  Y_WIDTH.

Function
REQ-019 SHALL hold an internal reference buffer of H_RES*V_RES words of NUM_CH*CH_WIDTH bits, addressed y*H_RES+x.
REQ-020 SHALL drop any valid pixel with x>=H_RES or y>=V_RES: no buffer write, no out_valid, no statistics update.
REQ-021 SHALL have a fixed 2-cycle pipeline: a pixel accepted in cycle N appears on out_* in cycle N+2. There is no stall; pix_valid gaps propagate as out_valid=0.
REQ-022 SHALL read the old word at the pixel address in stage 1; when freeze=0 it SHALL write the new pix_data to the same address in stage 2, after the read.
REQ-023 SHALL, when freeze=1, perform no writes, so the comparison is against the held frame.
REQ-024 SHALL forward a new pixel and not RAM-stale data when two consecutive accepted pixels share an address.
REQ-025 SHALL assert motion when any channel has |new-old| > threshold (unsigned, CH_WIDTH+1-bit difference). Equality is not motion.
REQ-026 SHALL select out_pixel by mode (MSB of each channel): 0=live MSBs; 1=reference MSBs; 2=motion replicated on all bits; 3=all ones if motion, else live MSBs.
REQ-027 SHALL implement the arming FSM: WARMUP (reset) -> FILL on first frame_start -> ARMED on next frame_start. ARMED is held until reset.
REQ-028 SHALL force motion=0 in WARMUP and FILL; the buffer is still written in those states.
REQ-029 SHALL accumulate a per-frame count of motion pixels, saturating at 2^CNT_WIDTH-1.
REQ-030 SHALL accumulate a per-frame bounding box as min/max x and y of motion pixels.
REQ-031 SHALL, on frame_start in ARMED, latch the accumulators to motion_count/bbox_* and clear them.
REQ-032 SHALL, on the cycle after the latch, pulse frame_done high for 1 cycle.
REQ-033 SHALL latch bbox_valid=1 only if count>0. Otherwise bbox_valid=0 and bbox_* = 0.
REQ-034 SHALL, when frame_start coincides with a pixel emerging from stage 2, count that pixel into the new frame.
REQ-035 SHALL ignore frame_start for statistics (no frame_done) outside ARMED, and take it only as an FSM transition.
REQ-036 SHALL take the threshold, mode and freeze values sampled with each pixel at stage 0 for that pixel.

Reset
REQ-037 SHALL, with resetn low, asynchronously clear out_valid, out_x, out_y, out_pixel, frame_done, motion_count, bbox_valid and bbox_* to 0, and clear the accumulators and pipeline valids.
REQ-038 SHALL enter WARMUP on reset. Buffer contents are not cleared.
REQ-039 SHALL discard in-flight pixels on reset mid-frame, with no partial statistics latched.

Verification
REQ-040 Bench SHALL cover latency: a single valid pixel (5,7) -> out_valid in exactly cycle +2 with out_x=5, out_y=7, mode 0 out_pixel = data MSBs.
REQ-041 Bench SHALL cover arming: frames 1–2 identical, frame 3 differs at 10 pixels by 8 with threshold=4 -> frame_done after frame-4 start, motion_count=10, bbox matches the pixels. No frame_done before ARMED.
REQ-042 Bench SHALL cover threshold edge: a difference equal to the threshold (4) gives no motion, and 5 gives motion, in mode 2 out_pixel = 3'b000 / 3'b111.
REQ-043 Bench SHALL cover freeze: reference frame A, then freeze=1 with frames B,B -> both frames report identical nonzero counts. With freeze=0 the second B frame gives a count of 0.
REQ-044 Bench SHALL cover boundaries: pixels at x=320 or y=240 produce no output or write. A same-address back-to-back pair gives the second compared against the first's data. frame_start together with a motion pixel counts it in the next frame.
REQ-045 Bench SHALL cover reset mid-frame: resetn low for 3 cycles -> all outputs 0, FSM in WARMUP, and the next two frame_starts give no frame_done.
